// File: rtl/fifo_nibble_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_nibble_reader_if
// Purpose  : FIFO read port plus word-wide valid/ready bus of the nibble reader
// Revision : 1.0
// ============================================================================
interface fifo_nibble_reader_if #(
    parameter int NIBBLE_W         = 4,
    parameter int NIBBLES_PER_WORD = 2,
    parameter int CNT_W            = 8
);
    logic                                 fifo_empty;
    logic                                 fifo_re;
    logic [NIBBLE_W-1:0]                  fifo_rdata;
    logic                                 flush;
    logic [NIBBLE_W*NIBBLES_PER_WORD-1:0] out_data;
    logic                                 out_valid;
    logic                                 out_ready;
    logic                                 partial;
    logic [CNT_W-1:0]                     word_count;

    modport master (
        input  fifo_empty, fifo_rdata, flush, out_ready,
        output fifo_re, out_data, out_valid, partial, word_count
    );

    modport slave (
        output fifo_empty, fifo_rdata, flush, out_ready,
        input  fifo_re, out_data, out_valid, partial, word_count
    );
endinterface
`default_nettype wire

// File: rtl/fifo_nibble_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_nibble_reader
// Purpose  : Drains a nibble FIFO and packs nibbles, LSB first, into words
// Revision : 1.0
// ============================================================================
module fifo_nibble_reader #(
    parameter int NIBBLE_W         = 4,
    parameter int NIBBLES_PER_WORD = 2,
    parameter int RD_LATENCY       = 1,
    parameter int CNT_W            = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    fifo_nibble_reader_if.master  bus
);
    localparam int WORD_W = NIBBLE_W * NIBBLES_PER_WORD;
    localparam int NC_W   = $clog2(NIBBLES_PER_WORD);
    localparam int WC_W   = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [NC_W-1:0] C_LAST_NIB  = NC_W'(NIBBLES_PER_WORD - 1);
    localparam logic [WC_W-1:0] C_LAST_WAIT = WC_W'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t              state_q,      state_d;
    logic [NC_W-1:0]     nib_cnt_q,    nib_cnt_d;
    logic [WC_W-1:0]     wait_cnt_q,   wait_cnt_d;
    logic [WORD_W-1:0]   out_data_q,   out_data_d;
    logic                out_valid_q,  out_valid_d;
    logic [CNT_W-1:0]    word_count_q, word_count_d;
    logic                fifo_re_q,    fifo_re_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            nib_cnt_q    <= '0;
            wait_cnt_q   <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            word_count_q <= '0;
            fifo_re_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            nib_cnt_q    <= nib_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            word_count_q <= word_count_d;
            fifo_re_q    <= fifo_re_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        nib_cnt_d    = nib_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        word_count_d = word_count_q;

        case (state_q)
            S_IDLE: begin
                if (!bus.fifo_empty) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                state_d    = S_WAIT;
                wait_cnt_d = '0;
            end
            S_WAIT: begin
                if (wait_cnt_q == C_LAST_WAIT) begin
                    for (int i = 0; i < NIBBLES_PER_WORD; i++) begin
                        if (nib_cnt_q == NC_W'(i)) begin
                            out_data_d[i*NIBBLE_W +: NIBBLE_W] = bus.fifo_rdata;
                        end
                    end
                    if (nib_cnt_q == C_LAST_NIB) begin
                        nib_cnt_d   = '0;
                        out_valid_d = 1'b1;
                        state_d     = S_OUT;
                    end else begin
                        nib_cnt_d = nib_cnt_q + 1'b1;
                        state_d   = bus.fifo_empty ? S_IDLE : S_RD;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d  = 1'b0;
                    word_count_d = word_count_q + 1'b1;
                    state_d      = bus.fifo_empty ? S_IDLE : S_RD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush overrides everything, including a handshake in the same cycle
        if (bus.flush) begin
            state_d      = S_IDLE;
            nib_cnt_d    = '0;
            out_valid_d  = 1'b0;
            out_data_d   = out_data_q;
            word_count_d = word_count_q;
        end

        fifo_re_d = (state_d == S_RD);
    end

    assign bus.fifo_re    = fifo_re_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.partial    = (nib_cnt_q != '0);
    assign bus.word_count = word_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_nibble_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_nibble_reader
// Purpose  : Scoreboard bench for fifo_nibble_reader (latency 1 and 2 instances)
// Revision : 1.0
// ============================================================================
module tb_fifo_nibble_reader;
    localparam int NW  = 4;
    localparam int NPW = 2;
    localparam int CW  = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;

    fifo_nibble_reader_if #(.NIBBLE_W(NW), .NIBBLES_PER_WORD(NPW), .CNT_W(CW)) bus1 ();
    fifo_nibble_reader_if #(.NIBBLE_W(NW), .NIBBLES_PER_WORD(NPW), .CNT_W(CW)) bus2 ();

    fifo_nibble_reader #(.NIBBLE_W(NW), .NIBBLES_PER_WORD(NPW), .RD_LATENCY(1), .CNT_W(CW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.master)
    );

    fifo_nibble_reader #(.NIBBLE_W(NW), .NIBBLES_PER_WORD(NPW), .RD_LATENCY(2), .CNT_W(CW)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.master)
    );

    // FIFO models: writer pointer owned by the stimulus, reader pointer by the model
    logic [NW-1:0] mem1 [0:1023];
    logic [NW-1:0] mem2 [0:1023];
    int            wr1 = 0, rd1 = 0, wr2 = 0, rd2 = 0;
    logic [NW-1:0] pipe2;

    assign bus1.fifo_empty = (wr1 == rd1);
    assign bus2.fifo_empty = (wr2 == rd2);

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
        if (bus1.fifo_re) begin
            bus1.fifo_rdata <= mem1[rd1 % 1024];
            rd1             <= rd1 + 1;
        end
        bus2.fifo_rdata <= pipe2;
        if (bus2.fifo_re) begin
            pipe2 <= mem2[rd2 % 1024];
            rd2   <= rd2 + 1;
        end
    end

    int            n_chk  = 0;
    int            n_fail = 0;
    int            re_cnt1 = 0;
    logic [7:0]    exp1_q [$];
    logic [7:0]    exp2_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push1(input logic [NW-1:0] n);
        mem1[wr1 % 1024] = n;
        wr1++;
    endtask

    task automatic push2(input logic [NW-1:0] n);
        mem2[wr2 % 1024] = n;
        wr2++;
    endtask

    // Monitor for the latency-1 instance
    initial begin
        logic       re_prev;
        logic [7:0] e;
        re_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus1.fifo_re) begin
                    re_cnt1++;
                    check("re1_single_cycle", {31'b0, re_prev}, 32'd0);
                end
                if (bus1.out_valid && bus1.out_ready && !bus1.flush) begin
                    if (exp1_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL sb1_unexpected: got word 0x%0h, expected no word", bus1.out_data);
                    end else begin
                        e = exp1_q.pop_front();
                        check("sb1_word", bus1.out_data, e);
                    end
                end
            end
            re_prev = bus1.fifo_re;
        end
    end

    // Monitor for the latency-2 instance: words plus read-pulse spacing
    initial begin
        int         k;
        int         last;
        logic [7:0] e;
        k    = 0;
        last = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus2.fifo_re) begin
                    if (k > 0) begin
                        check("re2_spacing", cyc - last, (k % 2 == 1) ? 32'd3 : 32'd4);
                    end
                    last = cyc;
                    k++;
                end
                if (bus2.out_valid && bus2.out_ready && !bus2.flush) begin
                    if (exp2_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL sb2_unexpected: got word 0x%0h, expected no word", bus2.out_data);
                    end else begin
                        e = exp2_q.pop_front();
                        check("sb2_word", bus2.out_data, e);
                    end
                end
            end
        end
    end

    task automatic drain1(input string name, input int budget);
        for (int t = 0; t < budget && exp1_q.size() != 0; t++) @(negedge clk);
        repeat (2) @(negedge clk);
        check(name, exp1_q.size(), 32'd0);
    endtask

    task automatic wait_valid1(input string name);
        for (int t = 0; t < 100 && !bus1.out_valid; t++) @(negedge clk);
        check(name, {31'b0, bus1.out_valid}, 32'd1);
    endtask

    initial begin
        int re_base;
        rst_n           = 1'b0;
        bus1.flush      = 1'b0;
        bus1.out_ready  = 1'b1;
        bus2.flush      = 1'b0;
        bus2.out_ready  = 1'b1;
        pipe2           = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_fifo_re",    {31'b0, bus1.fifo_re},   32'd0);
        check("rst_out_valid",  {31'b0, bus1.out_valid}, 32'd0);
        check("rst_out_data",   bus1.out_data,           32'd0);
        check("rst_partial",    {31'b0, bus1.partial},   32'd0);
        check("rst_word_count", bus1.word_count,         32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Latency-2 instance: 0..7 preloaded, drained concurrently
        for (int i = 0; i < 8; i++) push2(4'(i));
        for (int k = 0; k < 4; k++) exp2_q.push_back(8'(((2*k+1) << 4) | (2*k)));

        // Empty FIFO: reader must stay idle
        repeat (20) begin
            @(negedge clk);
            check("t3_idle", {29'b0, bus1.fifo_re, bus1.out_valid, bus1.partial}, 32'd0);
        end

        // Full drain with out_ready=1
        re_base = re_cnt1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) push1(4'(i));
        exp1_q.push_back(8'h10);
        exp1_q.push_back(8'h32);
        exp1_q.push_back(8'h54);
        exp1_q.push_back(8'h76);
        drain1("t1_drained", 200);
        check("t1_word_count", bus1.word_count, 32'd4);
        check("t1_re_pulses",  re_cnt1 - re_base, 32'd8);

        for (int t = 0; t < 200 && exp2_q.size() != 0; t++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("l2_drained",    exp2_q.size(),   32'd0);
        check("l2_word_count", bus2.word_count, 32'd4);

        // Backpressure on the first word
        @(posedge clk);
        #1;
        bus1.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push1(4'(i));
        exp1_q.push_back(8'h10);
        exp1_q.push_back(8'h32);
        wait_valid1("t2_valid_seen");
        repeat (10) begin
            @(negedge clk);
            check("t2_hold_data",  bus1.out_data,           32'h10);
            check("t2_hold_valid", {31'b0, bus1.out_valid}, 32'd1);
            check("t2_no_read",    {31'b0, bus1.fifo_re},   32'd0);
        end
        @(posedge clk);
        #1;
        bus1.out_ready = 1'b1;
        drain1("t2_drained", 200);
        check("t2_word_count", bus1.word_count, 32'd6);

        // Partial word then flush
        @(posedge clk);
        #1;
        push1(4'hA);
        for (int t = 0; t < 50 && !bus1.partial; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("t4_partial_set", {31'b0, bus1.partial}, 32'd1);
        @(posedge clk);
        #1;
        bus1.flush = 1'b1;
        @(posedge clk);
        #1;
        bus1.flush = 1'b0;
        @(negedge clk);
        check("t4_partial_clr", {31'b0, bus1.partial}, 32'd0);
        @(posedge clk);
        #1;
        push1(4'h3);
        push1(4'h4);
        exp1_q.push_back(8'h43);
        drain1("t4_drained", 100);
        check("t4_word_count", bus1.word_count, 32'd7);

        // Flush coinciding with a handshake: word dropped, count unchanged
        @(posedge clk);
        #1;
        bus1.out_ready = 1'b0;
        push1(4'h8);
        push1(4'h9);
        wait_valid1("fh_valid_seen");
        check("fh_word", bus1.out_data, 32'h98);
        @(posedge clk);
        #1;
        bus1.out_ready = 1'b1;
        bus1.flush     = 1'b1;
        @(posedge clk);
        #1;
        bus1.flush = 1'b0;
        @(negedge clk);
        check("fh_valid_clr",  {31'b0, bus1.out_valid}, 32'd0);
        check("fh_word_count", bus1.word_count,         32'd7);

        // Async reset while the second nibble is in flight
        @(posedge clk);
        #1;
        push1(4'h1);
        push1(4'h2);
        begin
            int t;
            t = 0;
            while (t < 50 && !(bus1.fifo_re && bus1.partial)) begin
                @(negedge clk);
                t++;
            end
        end
        check("t5_second_read", {30'b0, bus1.fifo_re, bus1.partial}, 32'd3);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_outputs",
              {bus1.word_count, bus1.out_data, 13'b0, bus1.fifo_re, bus1.out_valid, bus1.partial},
              32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push1(4'h5);
        push1(4'h6);
        exp1_q.push_back(8'h65);
        drain1("t5_drained", 100);
        check("t5_word_count", bus1.word_count, 32'd1);

        // 255 more words: count wraps to zero after 256 total
        @(posedge clk);
        #1;
        for (int k = 1; k < 256; k++) begin
            push1(4'(k));
            push1(4'(k >> 4));
            exp1_q.push_back(8'(k));
        end
        drain1("t6_drained", 3000);
        check("t6_word_count_wrap", bus1.word_count, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
